// File: rtl/fft16_ctrl.sv
// 16-point radix-2 DIF FFT sequencer: buffers one frame, runs 4x8 butterflies
// sharing an external (b - a)*W multiplier, then streams bins in natural order.
module fft16_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] din_r,
    input  logic [31:0] din_i,
    output logic        busy,
    output logic        out_valid,
    output logic [31:0] dout_r,
    output logic [31:0] dout_i,
    output logic        mul_valid,
    output logic [31:0] mul_a_r,
    output logic [31:0] mul_a_i,
    output logic [31:0] mul_b_r,
    output logic [31:0] mul_b_i,
    output logic [31:0] coff_r,
    output logic [31:0] coff_i,
    input  logic [31:0] mul_r,
    input  logic [31:0] mul_i
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CALC  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Upper butterfly leg: b with a zero bit inserted at position (3 - s).
    function automatic logic [3:0] bfly_top(input logic [1:0] s, input logic [2:0] b);
        logic [3:0] idx;
        case (s)
            2'd0:    idx = {1'b0, b};
            2'd1:    idx = {b[2], 1'b0, b[1:0]};
            2'd2:    idx = {b[2:1], 1'b0, b[0]};
            2'd3:    idx = {b, 1'b0};
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] tw_index(input logic [1:0] s, input logic [2:0] b);
        logic [2:0] k;
        case (s)
            2'd0:    k = b;
            2'd1:    k = {b[1:0], 1'b0};
            2'd2:    k = {b[0], 2'b00};
            2'd3:    k = 3'd0;
            default: k = 3'd0;
        endcase
        return k;
    endfunction

    // Q16.16 twiddles W[k] = exp(-j*2*pi*k/16), packed {real, imag}.
    function automatic logic [63:0] twiddle(input logic [2:0] k);
        logic signed [31:0] wr;
        logic signed [31:0] wi;
        case (k)
            3'd0:    begin wr =  32'sd65536; wi =  32'sd0;     end
            3'd1:    begin wr =  32'sd60547; wi = -32'sd25080; end
            3'd2:    begin wr =  32'sd46341; wi = -32'sd46341; end
            3'd3:    begin wr =  32'sd25080; wi = -32'sd60547; end
            3'd4:    begin wr =  32'sd0;     wi = -32'sd65536; end
            3'd5:    begin wr = -32'sd25080; wi = -32'sd60547; end
            3'd6:    begin wr = -32'sd46341; wi = -32'sd46341; end
            3'd7:    begin wr = -32'sd60547; wi = -32'sd25080; end
            default: begin wr =  32'sd0;     wi =  32'sd0;     end
        endcase
        return {wr, wi};
    endfunction

    function automatic logic [3:0] bitrev4(input logic [3:0] n);
        return {n[0], n[1], n[2], n[3]};
    endfunction

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  stage_q;
    logic [2:0]  bfly_q;
    logic [4:0]  n_q;
    logic        prod_pend_q;
    logic [3:0]  prod_idx_q;
    logic        busy_q;
    logic        out_valid_q;
    logic [31:0] dout_r_q;
    logic [31:0] dout_i_q;
    logic [31:0] x_r_q [0:15];
    logic [31:0] x_i_q [0:15];

    logic [3:0]  idx_i_s;
    logic [3:0]  idx_j_s;
    logic [63:0] tw_s;
    logic [31:0] sum_r_s;
    logic [31:0] sum_i_s;

    // Butterfly addressing and multiplier drive; operands are zero outside issue cycles.
    always_comb begin
        idx_i_s   = bfly_top(stage_q, bfly_q);
        idx_j_s   = idx_i_s | (4'd8 >> stage_q);
        tw_s      = twiddle(tw_index(stage_q, bfly_q));
        sum_r_s   = x_r_q[idx_i_s] + x_r_q[idx_j_s];
        sum_i_s   = x_i_q[idx_i_s] + x_i_q[idx_j_s];
        mul_valid = 1'b0;
        mul_b_r   = 32'd0;
        mul_b_i   = 32'd0;
        mul_a_r   = 32'd0;
        mul_a_i   = 32'd0;
        coff_r    = 32'd0;
        coff_i    = 32'd0;
        if (state_q == S_CALC) begin
            mul_valid = 1'b1;
            mul_b_r   = x_r_q[idx_i_s];
            mul_b_i   = x_i_q[idx_i_s];
            mul_a_r   = x_r_q[idx_j_s];
            mul_a_i   = x_i_q[idx_j_s];
            coff_r    = tw_s[63:32];
            coff_i    = tw_s[31:0];
        end else begin
            mul_valid = 1'b0;
        end
    end

    // Sample buffer: loads, sum-path writes and product writes (one cycle after issue).
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid) begin
            x_r_q[cnt_q] <= din_r;
            x_i_q[cnt_q] <= din_i;
        end
        if (state_q == S_CALC) begin
            x_r_q[idx_i_s] <= sum_r_s;
            x_i_q[idx_i_s] <= sum_i_s;
        end
        if (prod_pend_q) begin
            x_r_q[prod_idx_q] <= mul_r;
            x_i_q[prod_idx_q] <= mul_i;
        end
    end

    // Frame sequencer with registered busy and output stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= 4'd0;
            stage_q     <= 2'd0;
            bfly_q      <= 3'd0;
            n_q         <= 5'd0;
            prod_pend_q <= 1'b0;
            prod_idx_q  <= 4'd0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            dout_r_q    <= 32'd0;
            dout_i_q    <= 32'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd15) begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                            stage_q <= 2'd0;
                            bfly_q  <= 3'd0;
                        end
                    end
                end
                S_CALC: begin
                    prod_pend_q <= 1'b1;
                    prod_idx_q  <= idx_j_s;
                    bfly_q      <= bfly_q + 3'd1;
                    if (bfly_q == 3'd7) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    prod_pend_q <= 1'b0;
                    if (stage_q == 2'd3) begin
                        state_q <= S_OUT;
                        n_q     <= 5'd0;
                    end else begin
                        stage_q <= stage_q + 2'd1;
                        state_q <= S_CALC;
                    end
                end
                S_OUT: begin
                    // Extra pass at n = 16 keeps busy high through the last bin.
                    if (!n_q[4]) begin
                        dout_r_q    <= x_r_q[bitrev4(n_q[3:0])];
                        dout_i_q    <= x_i_q[bitrev4(n_q[3:0])];
                        out_valid_q <= 1'b1;
                        n_q         <= n_q + 5'd1;
                    end else begin
                        dout_r_q    <= 32'd0;
                        dout_i_q    <= 32'd0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cnt_q       <= 4'd0;
                        state_q     <= S_LOAD;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_fft16_ctrl.sv
// Self-checking bench for fft16_ctrl: behavioural Q16.16 multiplier plus an
// output scoreboard of expected spectrum bins.
module tb_fft16_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] din_r, din_i;
    logic        busy, out_valid, mul_valid;
    logic [31:0] dout_r, dout_i;
    logic [31:0] mul_a_r, mul_a_i, mul_b_r, mul_b_i, coff_r, coff_i;
    logic [31:0] mul_r, mul_i;

    fft16_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
        .busy(busy), .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i),
        .mul_valid(mul_valid), .mul_a_r(mul_a_r), .mul_a_i(mul_a_i),
        .mul_b_r(mul_b_r), .mul_b_i(mul_b_i), .coff_r(coff_r), .coff_i(coff_i),
        .mul_r(mul_r), .mul_i(mul_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int i;
        int tol;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_cnt = 0, out_start = -1, mul_cnt = 0, acc_cnt = 0, last_acc = -1;
    int   overlap_cnt = 0, nz_cnt = 0;
    bit   prev_ov = 1'b0, first_seen = 1'b0;
    logic [31:0] first_coff_r = 32'd0, first_coff_i = 32'd0;
    int   wtab_r[8] = '{65536, 60547, 46341, 25080, 0, -25080, -46341, -60547};
    int   wtab_i[8] = '{0, -25080, -46341, -60547, -65536, -60547, -46341, -25080};
    longint mdr, mdi, mwr, mwi, mpr, mpi;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: registered (b - a) * W, Q16.16 floor; junk when idle.
    always @(posedge clk) begin
        if (mul_valid) begin
            mdr = longint'($signed(mul_b_r)) - longint'($signed(mul_a_r));
            mdi = longint'($signed(mul_b_i)) - longint'($signed(mul_a_i));
            mwr = longint'($signed(coff_r));
            mwi = longint'($signed(coff_i));
            mpr = (mdr * mwr - mdi * mwi) >>> 16;
            mpi = (mdr * mwi + mdi * mwr) >>> 16;
            mul_r <= mpr[31:0];
            mul_i <= mpi[31:0];
        end else begin
            mul_r <= 32'h5A5A_5A5A;
            mul_i <= 32'hA5A5_A5A5;
        end
    end

    // Output monitor: pops the scoreboard and tracks protocol counters.
    always @(negedge clk) begin
        exp_t   e;
        longint dr, di;
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) out_start = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out cyc=%0d got (%0d,%0d) want none", cyc,
                             $signed(dout_r), $signed(dout_i));
                end else begin
                    e  = sb.pop_front();
                    dr = longint'($signed(dout_r)) - longint'(e.r);
                    di = longint'($signed(dout_i)) - longint'(e.i);
                    if (dr < 0) dr = -dr;
                    if (di < 0) di = -di;
                    if (dr > e.tol || di > e.tol) begin
                        errors++;
                        $display("FAIL bin%0d got (%0d,%0d) want (%0d,%0d) tol %0d", out_cnt % 16,
                                 $signed(dout_r), $signed(dout_i), e.r, e.i, e.tol);
                    end
                end
                out_cnt++;
            end
            prev_ov = out_valid;
            if (mul_valid) begin
                mul_cnt++;
                if (!first_seen) begin
                    first_seen   = 1'b1;
                    first_coff_r = coff_r;
                    first_coff_i = coff_i;
                end
            end
            if (mul_valid && out_valid) overlap_cnt++;
            if (!mul_valid && (mul_a_r | mul_a_i | mul_b_r | mul_b_i | coff_r | coff_i) != 32'd0)
                nz_cnt++;
            if (in_valid && !busy) begin
                acc_cnt++;
                last_acc = cyc;
            end
        end
    end

    task automatic push_bin(input int r, input int i, input int tol);
        exp_t e;
        e.r = r; e.i = i; e.tol = tol;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int xr[16], input int xi[16], input bit gap, output int c0);
        c0 = 0;
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1;
            din_r    = xr[n];
            din_i    = xi[n];
            step();
            c0 = cyc - 1;
            if (gap) begin
                in_valid = 1'b0;
                din_r    = $urandom();
                din_i    = $urandom();
                step();
            end
        end
        in_valid = 1'b0;
        din_r    = 32'd0;
        din_i    = 32'd0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && sb.size() != 0; t++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
        repeat (3) step();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; din_r = 32'd0; din_i = 32'd0;
        repeat (3) step();
        checks++;
        if ({busy, out_valid, mul_valid} !== 3'b000 || dout_r !== 32'd0 || dout_i !== 32'd0 ||
            (mul_a_r | mul_a_i | mul_b_r | mul_b_i | coff_r | coff_i) !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b ov=%b mv=%b dout=%h want all 0",
                     busy, out_valid, mul_valid, dout_r);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_impulse();
        int c0;
        int xr[16], xi[16];
        for (int n = 0; n < 16; n++) begin xr[n] = 0; xi[n] = 0; end
        xr[0] = 65536;
        for (int k = 0; k < 16; k++) push_bin(65536, 0, 0);
        out_cnt = 0; acc_cnt = 0;
        send_frame(xr, xi, 1'b0, c0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b want 1", busy); end
        checks++;
        if (acc_cnt != 16) begin errors++; $display("FAIL accepted got %0d want 16", acc_cnt); end
        wait_until(c0 + 53);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold got %b want 1", busy); end
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall got %b want 0", busy); end
        wait_drain();
        checks++;
        if (out_start != c0 + 38 || out_cnt != 16) begin
            errors++;
            $display("FAIL out_timing got start %0d count %0d want %0d 16", out_start, out_cnt, c0 + 38);
        end
    endtask

    task automatic test_dc();
        int c0;
        int xr[16], xi[16];
        for (int n = 0; n < 16; n++) begin xr[n] = 65536; xi[n] = 0; end
        push_bin(1048576, 0, 0);
        for (int k = 1; k < 16; k++) push_bin(0, 0, 0);
        send_frame(xr, xi, 1'b0, c0);
        wait_drain();
    endtask

    task automatic test_shifted();
        int c0;
        int xr[16], xi[16];
        for (int n = 0; n < 16; n++) begin xr[n] = 0; xi[n] = 0; end
        xr[1] = 65536;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) push_bin(wtab_r[k], wtab_i[k], 2);
            else       push_bin(-wtab_r[k - 8], -wtab_i[k - 8], 2);
        end
        mul_cnt = 0; first_seen = 1'b0;
        send_frame(xr, xi, 1'b0, c0);
        wait_drain();
        checks++;
        if (mul_cnt != 32) begin errors++; $display("FAIL mul_pulses got %0d want 32", mul_cnt); end
        checks++;
        if (first_coff_r !== 32'd65536 || first_coff_i !== 32'd0) begin
            errors++;
            $display("FAIL first_coff got (%0d,%0d) want (65536,0)", $signed(first_coff_r), $signed(first_coff_i));
        end
    endtask

    task automatic test_gapped_busy();
        int c0;
        int xr[16], xi[16];
        for (int n = 0; n < 16; n++) begin xr[n] = 0; xi[n] = 0; end
        xr[0] = 65536;
        for (int k = 0; k < 16; k++) push_bin(65536, 0, 0);
        send_frame(xr, xi, 1'b1, c0);
        for (int t = 0; t < 30; t++) begin
            in_valid = t[0];
            din_r    = $urandom();
            din_i    = $urandom();
            step();
        end
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int c0;
        int xr[16], xi[16];
        for (int n = 0; n < 16; n++) begin xr[n] = 65536; xi[n] = 0; end
        send_frame(xr, xi, 1'b0, c0);
        wait_until(c0 + 20);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, out_valid, mul_valid} !== 3'b000 || dout_r !== 32'd0 ||
            (mul_a_r | mul_a_i | mul_b_r | mul_b_i | coff_r | coff_i) !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b ov=%b mv=%b coff=%h want all 0", busy, out_valid, mul_valid, coff_r);
        end
        step();
        rst = 1'b0;
        out_cnt = 0;
        repeat (80) step();
        checks++;
        if (out_cnt != 0) begin errors++; $display("FAIL abort_out got %0d bins want 0", out_cnt); end
        test_dc();
    endtask

    task automatic test_back_to_back();
        int c0;
        for (int k = 0; k < 16; k++) push_bin(65536, 0, 0);
        push_bin(1048576, 0, 0);
        for (int k = 1; k < 16; k++) push_bin(0, 0, 0);
        acc_cnt = 0; c0 = 0;
        for (int n = 0; n < 16; n++) begin
            in_valid = 1'b1;
            din_r    = (n == 0) ? 65536 : 0;
            din_i    = 32'd0;
            step();
            c0 = cyc - 1;
        end
        din_r = 65536;
        for (int t = 0; t < 200 && acc_cnt < 32; t++) step();
        in_valid = 1'b0;
        din_r    = 32'd0;
        checks++;
        if (last_acc != c0 + 69) begin
            errors++;
            $display("FAIL second_accept got %0d want %0d", last_acc, c0 + 69);
        end
        wait_drain();
        checks++;
        if (out_start != c0 + 69 + 38) begin
            errors++;
            $display("FAIL second_out_start got %0d want %0d", out_start, c0 + 107);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_shifted();
        test_gapped_busy();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (overlap_cnt != 0) begin errors++; $display("FAIL out_mul_overlap got %0d want 0", overlap_cnt); end
        checks++;
        if (nz_cnt != 0) begin errors++; $display("FAIL idle_operands got %0d want 0", nz_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
